// File: rtl/lms_ctr_nios2_cpu_cpu_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// lms_ctr_nios2_cpu_cpu_debug_ocimem_ctrl
//
// Debug-monitor RAM controller. It serves JTAG-originated accesses, which
// arrive as decoded jdo words plus one-cycle strobes from the sysclk stage,
// and CPU Avalon accesses to the same RAM. When both arrive in the same
// IDLE cycle, JTAG wins.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a JTAG strobe or a CPU request
// J_RD1 | RAM read issued at MonAReg
// J_RD2 | RAM data captured into MonDReg, monitor_ready raised
// J_WR  | latched JTAG data written at MonAReg, MonAReg incremented
// C_RD1 | CPU read data (issued in IDLE) captured into avs_readdata
// C_RD2 | CPU read completes (waitrequest low)
// C_WR  | CPU write completes (waitrequest low), gated by debugaccess
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   jdo[37:0]                JTAG data word (addr [25+ADDR_W:26], rd [25],
//                            clear-error [35], write data [34:3])
//   take_action_ocimem_a/b,  JTAG strobes (load/read, write, read-next)
//   take_no_action_ocimem_a
//   avs_*                    Avalon-MM slave for the CPU
//   debugaccess              CPU write qualifier
//   MonDReg, monitor_ready,  JTAG read data, completion flag and sticky
//   monitor_error            overrun flag
// ---------------------------------------------------------------------------
module lms_ctr_nios2_cpu_cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              debugaccess,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        IDLE, J_RD1, J_RD2, J_WR, C_RD1, C_RD2, C_WR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] mon_areg;
    logic [31:0]       wr_data;
    logic              rd_inc;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              any_strobe;
    logic              unused_jdo;

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // The CPU read is issued from IDLE so its data is already in ram_q during
    // C_RD1; that lets avs_readdata be valid in C_RD2, the cycle the master
    // samples it. Every other state reads at MonAReg.
    assign ram_addr = (state == IDLE) ? avs_address : mon_areg;

    // Only the completing CPU cycles release the master.
    assign avs_waitrequest = !((state == C_WR) || (state == C_RD2));

    always_ff @(posedge clk) begin
        if (state == J_WR) begin
            mem[mon_areg] <= wr_data;
        end else if ((state == C_WR) && debugaccess) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b]) begin
                    mem[avs_address][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_areg      <= '0;
            wr_data       <= '0;
            rd_inc        <= 1'b0;
            MonDReg       <= '0;
            avs_readdata  <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            // Strobes outside IDLE are dropped and flagged.
            if ((state != IDLE) && any_strobe) begin
                monitor_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        mon_areg <= jdo[25+ADDR_W:26];
                        rd_inc   <= 1'b0;
                        if (jdo[35]) begin
                            monitor_error <= 1'b0;
                        end
                        if (jdo[25]) begin
                            monitor_ready <= 1'b0;
                            state         <= J_RD1;
                        end else begin
                            monitor_ready <= 1'b1;
                        end
                    end else if (take_action_ocimem_b) begin
                        wr_data       <= jdo[34:3];
                        monitor_ready <= 1'b0;
                        state         <= J_WR;
                    end else if (take_no_action_ocimem_a) begin
                        rd_inc        <= 1'b1;
                        monitor_ready <= 1'b0;
                        state         <= J_RD1;
                    end else if (avs_write) begin
                        state <= C_WR;
                    end else if (avs_read) begin
                        state <= C_RD1;
                    end
                end
                J_RD1: state <= J_RD2;
                J_RD2: begin
                    MonDReg       <= ram_q;
                    monitor_ready <= 1'b1;
                    if (rd_inc) begin
                        mon_areg <= mon_areg + ADDR_W'(1);
                    end
                    state <= IDLE;
                end
                J_WR: begin
                    mon_areg      <= mon_areg + ADDR_W'(1);
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                C_RD1: begin
                    avs_readdata <= ram_q;
                    state        <= C_RD2;
                end
                C_RD2:   state <= IDLE;
                C_WR:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_ctr_nios2_cpu_cpu_debug_ocimem_ctrl.sv
module tb_lms_ctr_nios2_cpu_cpu_debug_ocimem_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [37:0]   jdo;
    logic          take_a, take_b, take_no;
    logic [AW-1:0] avs_address;
    logic          avs_read, avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic          debugaccess;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;
    logic [31:0]   MonDReg;
    logic          monitor_ready, monitor_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lms_ctr_nios2_cpu_cpu_debug_ocimem_ctrl #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_no),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .debugaccess             (debugaccess),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // op: 0 jtag load, 1 jtag load+read, 2 jtag write, 3 jtag read-next,
    //     4 cpu write, 5 cpu read
    typedef struct {
        int          op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        dbg;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [18];
    logic [31:0] mem_m [DEPTH];
    logic [7:0]  areg_m;
    logic [31:0] rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe at cycle N; monitor_ready must rise exactly at N+lat.
    task automatic jtag(input int kind, input logic [7:0] addr, input logic [31:0] data,
                        input logic clr, output logic [31:0] rdata);
        logic [37:0] j;
        int          lat;
        j = '0;
        case (kind)
            0, 1: begin
                j[33:26] = addr;
                j[25]    = (kind == 1);
                j[35]    = clr;
                take_a   = 1'b1;
                lat      = (kind == 1) ? 3 : 1;
            end
            2: begin
                j[34:3] = data;
                take_b  = 1'b1;
                lat     = 2;
            end
            default: begin
                take_no = 1'b1;
                lat     = 3;
            end
        endcase
        jdo = j;
        step();
        take_a  = 1'b0;
        take_b  = 1'b0;
        take_no = 1'b0;
        for (int c = 1; c < lat; c++) begin
            check("jtag_ready_early", 32'(monitor_ready), 32'd0);
            step();
        end
        check("jtag_ready_latency", 32'(monitor_ready), 32'd1);
        rdata = MonDReg;
    endtask

    // Request held from cycle 1; waitrequest must drop on cycle 2 (write) or 3 (read).
    task automatic cpu(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic dbg, output logic [31:0] rdata);
        int cyc;
        avs_address    = addr;
        avs_write      = we;
        avs_read       = !we;
        avs_writedata  = wd;
        avs_byteenable = be;
        debugaccess    = dbg;
        cyc = 1;
        while (avs_waitrequest === 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        check(we ? "cpu_wr_cycle" : "cpu_rd_cycle", 32'(cyc), we ? 32'd2 : 32'd3);
        rdata = avs_readdata;
        step();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; jdo = '0; take_a = 0; take_b = 0; take_no = 0;
        avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
        avs_byteenable = '0; debugaccess = 0;

        tbl[0]  = '{0, 8'h10, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{2, 8'h00, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1, 8'h10, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[3]  = '{3, 8'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[4]  = '{0, 8'hFF, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{2, 8'h00, 32'hAAAA5555, 4'h0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{2, 8'h00, 32'h5A5A0F0F, 4'h0, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{0, 8'hFF, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{3, 8'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'hAAAA5555};
        tbl[9]  = '{3, 8'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'h5A5A0F0F};
        tbl[10] = '{4, 8'h20, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{4, 8'h20, 32'h12345678, 4'h3, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{5, 8'h20, 32'h0,        4'h0, 1'b0, 1'b1, 32'hFFFF5678};
        tbl[13] = '{4, 8'h20, 32'h00000000, 4'hF, 1'b0, 1'b0, 32'h0};
        tbl[14] = '{5, 8'h20, 32'h0,        4'h0, 1'b0, 1'b1, 32'hFFFF5678};
        tbl[15] = '{1, 8'h20, 32'h0,        4'h0, 1'b0, 1'b1, 32'hFFFF5678};
        tbl[16] = '{5, 8'hFF, 32'h0,        4'h0, 1'b0, 1'b1, 32'hAAAA5555};
        tbl[17] = '{5, 8'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'h5A5A0F0F};

        step(); step();
        reset_n = 1'b1;
        step(); step();
        check("rst_mondreg",  MonDReg, 32'h0);
        check("rst_ready",    32'(monitor_ready), 32'd0);
        check("rst_error",    32'(monitor_error), 32'd0);
        check("rst_waitreq",  32'(avs_waitrequest), 32'd1);
        check("rst_readdata", avs_readdata, 32'h0);

        // Directed table
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].op < 4)
                jtag(tbl[i].op, tbl[i].addr, tbl[i].data, 1'b0, rd);
            else
                cpu(tbl[i].op == 4, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].dbg, rd);
            if (tbl[i].chk) check($sformatf("table_%0d", i), rd, tbl[i].exp);
        end
        check("table_no_error", 32'(monitor_error), 32'd0);

        // Overrun: read-next strobe during J_WR is dropped and flagged
        jtag(0, 8'h31, 32'h0, 1'b0, rd);
        jtag(2, 8'h00, 32'h22222222, 1'b0, rd);
        jtag(0, 8'h30, 32'h0, 1'b0, rd);
        jdo = '0; jdo[34:3] = 32'h11111111; take_b = 1'b1;
        step();
        take_b = 1'b0; take_no = 1'b1;
        step();
        take_no = 1'b0;
        check("ovr_write_ready", 32'(monitor_ready), 32'd1);
        check("ovr_error_set", 32'(monitor_error), 32'd1);
        step(); step(); step();
        check("ovr_error_sticky", 32'(monitor_error), 32'd1);
        jtag(3, 8'h00, 32'h0, 1'b0, rd);
        check("ovr_dropped_no_inc", rd, 32'h22222222);
        jtag(0, 8'h30, 32'h0, 1'b0, rd);
        check("ovr_clr0_keeps", 32'(monitor_error), 32'd1);
        jtag(1, 8'h30, 32'h0, 1'b1, rd);
        check("ovr_written_data", rd, 32'h11111111);
        check("ovr_cleared", 32'(monitor_error), 32'd0);

        // Contention: CPU read and JTAG read-next in the same IDLE cycle
        jtag(0, 8'h40, 32'h0, 1'b0, rd);
        jtag(2, 8'h00, 32'h44444444, 1'b0, rd);
        jtag(0, 8'h40, 32'h0, 1'b0, rd);
        cpu(1'b1, 8'h50, 32'h55555555, 4'hF, 1'b1, rd);
        avs_address = 8'h50; avs_read = 1'b1; take_no = 1'b1;
        step();
        take_no = 1'b0;
        step(); step();
        check("cont_jtag_ready", 32'(monitor_ready), 32'd1);
        check("cont_jtag_data", MonDReg, 32'h44444444);
        check("cont_cpu_wait3", 32'(avs_waitrequest), 32'd1);
        step();
        check("cont_cpu_wait4", 32'(avs_waitrequest), 32'd1);
        step();
        check("cont_cpu_wait5", 32'(avs_waitrequest), 32'd0);
        check("cont_cpu_data", avs_readdata, 32'h55555555);
        step();
        avs_read = 1'b0;
        check("cont_no_error", 32'(monitor_error), 32'd0);

        // Randomized traffic against a transaction-level model
        jtag(0, 8'h00, 32'h0, 1'b0, rd);
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = $urandom();
            jtag(2, 8'h00, mem_m[a], 1'b0, rd);
        end
        areg_m = 8'h00;
        for (int n = 0; n < 300; n++) begin
            int          k;
            logic [7:0]  a;
            logic [31:0] d;
            logic [3:0]  be;
            logic        dbg;
            k   = int'($urandom_range(5, 0));
            a   = 8'($urandom());
            d   = $urandom();
            be  = 4'($urandom());
            dbg = 1'($urandom());
            case (k)
                0: begin jtag(0, a, d, 1'b0, rd); areg_m = a; end
                1: begin
                    jtag(1, a, d, 1'b0, rd);
                    areg_m = a;
                    check("rand_jtag_load_rd", rd, mem_m[a]);
                end
                2: begin jtag(2, a, d, 1'b0, rd); mem_m[areg_m] = d; areg_m = areg_m + 8'd1; end
                3: begin
                    jtag(3, a, d, 1'b0, rd);
                    check("rand_jtag_next_rd", rd, mem_m[areg_m]);
                    areg_m = areg_m + 8'd1;
                end
                4: begin
                    cpu(1'b1, a, d, be, dbg, rd);
                    if (dbg)
                        for (int b = 0; b < 4; b++)
                            if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
                end
                default: begin
                    cpu(1'b0, a, d, be, dbg, rd);
                    check("rand_cpu_rd", rd, mem_m[a]);
                end
            endcase
        end
        check("rand_no_error", 32'(monitor_error), 32'd0);

        // Reset in the middle of a JTAG read
        jtag(1, 8'h10, 32'h0, 1'b0, rd);
        take_no = 1'b1;
        step();
        take_no = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_mondreg", MonDReg, 32'h0);
        check("midrst_ready", 32'(monitor_ready), 32'd0);
        check("midrst_waitreq", 32'(avs_waitrequest), 32'd1);
        step();
        reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
